// File: rtl/board_vga_renderer.sv
// Double-buffered 16x16 life board rendered as 640x480@60 VGA, cells CELL_PX square.
// Optional macro GRID_LINES_EN: draw 12'h444 on each cell's first pixel column and row.
module board_vga_renderer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter int CELL_PX = 30,
  parameter int BOARD_X0 = 80,
  parameter int BOARD_Y0 = 0,
  parameter logic [11:0] ALIVE_RGB = 12'hFFF,
  parameter logic [11:0] DEAD_RGB = 12'h111,
  parameter logic [11:0] BG_RGB = 12'h000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pix_ce,
  input  logic [255:0] board_in,
  input  logic         board_valid,
  output logic         board_ack,
  output logic         frame_start,
  output logic         hsync,
  output logic         vsync,
  output logic [11:0]  rgb
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int SW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;

  logic [HW-1:0] h_cnt, h_next;
  logic [VW-1:0] v_cnt, v_next;
  logic          h_last, v_last;

  logic [3:0]    col, row;
  logic [SW-1:0] sub_x, sub_y;
  logic          x_in, y_in;

  logic [255:0]  shadow, display;
  logic          pending, promote;

  logic          active, in_board;
  logic          hs_n, vs_n;
  logic [11:0]   pix_rgb;

  always_comb begin
    h_last = (h_cnt == HW'(H_TOTAL - 1));
    v_last = (v_cnt == VW'(V_TOTAL - 1));
    h_next = h_last ? '0 : h_cnt + 1'b1;
    v_next = v_cnt;
    if (h_last)
      v_next = v_last ? '0 : v_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      h_cnt <= h_next;
      v_cnt <= v_next;
    end
  end

  // Cell address counters track the pixel currently at (h_cnt, v_cnt).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col   <= '0;
      sub_x <= '0;
      x_in  <= 1'b0;
    end else if (pix_ce) begin
      if (h_next == HW'(BOARD_X0)) begin
        col   <= '0;
        sub_x <= '0;
        x_in  <= 1'b1;
      end else if (sub_x == SW'(CELL_PX - 1)) begin
        sub_x <= '0;
        col   <= col + 4'd1;
        if (col == 4'd15)
          x_in <= 1'b0;
      end else begin
        sub_x <= sub_x + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row   <= '0;
      sub_y <= '0;
      y_in  <= (BOARD_Y0 == 0);
    end else if (pix_ce && h_last) begin
      if (v_next == VW'(BOARD_Y0)) begin
        row   <= '0;
        sub_y <= '0;
        y_in  <= 1'b1;
      end else if (sub_y == SW'(CELL_PX - 1)) begin
        sub_y <= '0;
        row   <= row + 4'd1;
        if (row == 4'd15)
          y_in <= 1'b0;
      end else begin
        sub_y <= sub_y + 1'b1;
      end
    end
  end

  always_comb begin
    active   = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    in_board = x_in && y_in;
    hs_n = !((h_cnt >= HW'(H_ACTIVE + H_FP)) &&
             (h_cnt < HW'(H_ACTIVE + H_FP + H_SYNC)));
    vs_n = !((v_cnt >= VW'(V_ACTIVE + V_FP)) &&
             (v_cnt < VW'(V_ACTIVE + V_FP + V_SYNC)));
    pix_rgb = 12'h000;
    if (active) begin
      if (in_board)
        pix_rgb = display[{row, col}] ? ALIVE_RGB : DEAD_RGB;
      else
        pix_rgb = BG_RGB;
`ifdef GRID_LINES_EN
      if (in_board && (sub_x == '0 || sub_y == '0))
        pix_rgb = 12'h444;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      rgb         <= 12'h000;
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_ce && (h_cnt == '0) && (v_cnt == '0);
      if (pix_ce) begin
        hsync <= hs_n;
        vsync <= vs_n;
        rgb   <= pix_rgb;
      end
    end
  end

  // Swap only at the start of vblank so a frame never mixes generations.
  assign promote = pix_ce && pending && (h_cnt == '0) &&
                   (v_cnt == VW'(V_ACTIVE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow    <= '0;
      display   <= '0;
      pending   <= 1'b0;
      board_ack <= 1'b0;
    end else begin
      board_ack <= promote;
      if (promote)
        display <= shadow;
      if (board_valid) begin
        shadow  <= board_in;
        pending <= 1'b1;
      end else if (promote) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_board_vga_renderer.sv
// Directed bench for board_vga_renderer on a scaled 48x40 raster, 2-px cells.
// Honours GRID_LINES_EN for the cell-origin pixel expectation.
module tb_board_vga_renderer;

  localparam int TH = 48;
  localparam int TV = 40;
  localparam int LIM = 2 * TH * TV + 10;
  localparam logic [11:0] ALV = 12'hFFF;
  localparam logic [11:0] DED = 12'h111;
  localparam logic [11:0] BLK = 12'h000;
`ifdef GRID_LINES_EN
  localparam logic [11:0] ORG = 12'h444;
`else
  localparam logic [11:0] ORG = 12'h111;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pix_ce = 1'b0;
  logic [255:0] board_in = '0;
  logic         board_valid = 1'b0;
  logic         board_ack, frame_start, hsync, vsync;
  logic [11:0]  rgb;

  int errors = 0;
  int checks = 0;
  int cnt_h = 0, cnt_v = 0, obs_h = 0, obs_v = 0;
  int hl = 0, vl = 0, fs_cnt = 0, ack_cnt = 0;
  logic s_hs, s_vs, s_fs, s_ack;
  logic [11:0] s_rgb;

  board_vga_renderer #(
    .H_ACTIVE(40), .H_FP(2), .H_SYNC(4), .H_BP(2),
    .V_ACTIVE(34), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .CELL_PX(2), .BOARD_X0(4), .BOARD_Y0(0)
  ) dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce),
    .board_in(board_in), .board_valid(board_valid),
    .board_ack(board_ack), .frame_start(frame_start),
    .hsync(hsync), .vsync(vsync), .rgb(rgb)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (frame_start) fs_cnt++;
      if (board_ack) ack_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] bitv(input int i);
    logic [255:0] b;
    b = '0;
    b[i] = 1'b1;
    return b;
  endfunction

  // One pix_ce clock then one idle clock; samples describe pixel (obs_h, obs_v).
  task automatic step(input logic bv, input logic [255:0] bd);
    pix_ce = 1'b1;
    board_valid = bv;
    board_in = bd;
    @(posedge clk);
    #1;
    pix_ce = 1'b0;
    board_valid = 1'b0;
    s_hs = hsync;
    s_vs = vsync;
    s_rgb = rgb;
    s_fs = frame_start;
    s_ack = board_ack;
    obs_h = cnt_h;
    obs_v = cnt_v;
    if (cnt_h == TH - 1) begin
      cnt_h = 0;
      cnt_v = (cnt_v == TV - 1) ? 0 : cnt_v + 1;
    end else begin
      cnt_h++;
    end
    if (!s_hs) hl++;
    if (!s_vs) vl++;
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int h, input int v);
    int n;
    n = 0;
    do begin
      step(1'b0, '0);
      n++;
    end while (!(obs_h == h && obs_v == v) && n < LIM);
    if (n >= LIM) begin
      checks++;
      errors++;
      $error("FAIL goto got=%0d,%0d exp=%0d,%0d", obs_h, obs_v, h, v);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 1);
    chk("rst_rgb", rgb, 0);
    chk("rst_ack", board_ack, 0);
    chk("rst_fs", frame_start, 0);
    reset = 1'b0;
    fs_cnt = 0;
    ack_cnt = 0;

    // Timing over one full frame
    for (int i = 0; i < TH * TV; i++) begin
      step(1'b0, '0);
      if (i == 0) chk("fs_first", s_fs, 1);
    end
    chk("hsync_low_cnt", hl, 40 * 4);
    chk("vsync_low_cnt", vl, 2 * TH);
    chk("fs_per_frame", fs_cnt, 1);

    // Cell (0,0) captured mid-frame
    goto(1, 0);
    step(1'b1, bitv(0));
    goto(5, 1);
    chk("t2_old_frame", s_rgb, DED);
    goto(41, 1);
    chk("hs_before", s_hs, 1);
    goto(42, 1);
    chk("hs_start", s_hs, 0);
    goto(45, 1);
    chk("hs_end", s_hs, 0);
    goto(46, 1);
    chk("hs_after", s_hs, 1);
    goto(0, 34);
    chk("t2_ack", s_ack, 1);
    goto(47, 35);
    chk("vs_before", s_vs, 1);
    goto(0, 36);
    chk("vs_start", s_vs, 0);
    goto(47, 37);
    chk("vs_end", s_vs, 0);
    goto(0, 38);
    chk("vs_after", s_vs, 1);

    goto(3, 1);
    chk("t2_bg_left", s_rgb, BLK);
    goto(5, 1);
    chk("t2_alive", s_rgb, ALV);
    goto(7, 1);
    chk("t2_next_col", s_rgb, DED);
    goto(5, 3);
    chk("t2_next_row", s_rgb, DED);

    // Cell (15,15)
    goto(9, 10);
    step(1'b1, bitv(255));
    goto(0, 0);
    goto(33, 31);
    chk("t3_dead", s_rgb, DED);
    goto(35, 31);
    chk("t3_alive", s_rgb, ALV);
    goto(36, 31);
    chk("t3_bg_right", s_rgb, BLK);
    goto(35, 32);
    chk("t3_bg_below", s_rgb, BLK);
    goto(35, 34);
    chk("t3_blank", s_rgb, BLK);

    // Two captures in one frame: last wins, single ack
    ack_cnt = 0;
    goto(39, 34);
    step(1'b1, bitv(1));
    goto(41, 34);
    step(1'b1, bitv(16));
    goto(0, 0);
    goto(0, 35);
    chk("t4_ack_cnt", ack_cnt, 1);
    goto(7, 1);
    chk("t4_a_gone", s_rgb, DED);
    goto(5, 3);
    chk("t4_b_shown", s_rgb, ALV);

    // Capture on the promote clock
    ack_cnt = 0;
    goto(9, 10);
    step(1'b1, bitv(17));
    goto(47, 33);
    step(1'b1, bitv(2));
    chk("t5_ack1", s_ack, 1);
    goto(9, 1);
    chk("t5_d_pending", s_rgb, DED);
    goto(7, 3);
    chk("t5_c_shown", s_rgb, ALV);
    goto(0, 34);
    chk("t5_ack2", s_ack, 1);
    goto(0, 35);
    chk("t5_ack_cnt", ack_cnt, 2);
    goto(9, 1);
    chk("t5_d_shown", s_rgb, ALV);
    goto(7, 3);
    chk("t5_c_gone", s_rgb, DED);

    // Asynchronous reset mid-line
    goto(44, 3);
    chk("t6_hs_low", s_hs, 0);
    reset = 1'b1;
    #2;
    chk("t6_hsync", hsync, 1);
    chk("t6_vsync", vsync, 1);
    chk("t6_ack", board_ack, 0);
    chk("t6_fs", frame_start, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    cnt_h = 0;
    cnt_v = 0;
    step(1'b0, '0);
    chk("t6_restart_fs", s_fs, 1);
    goto(4, 0);
    chk("t6_origin", s_rgb, ORG);
    goto(5, 1);
    chk("t6_cell_px", s_rgb, DED);
    goto(9, 1);
    chk("t6_cleared", s_rgb, DED);
    goto(7, 3);
    reset = 1'b1;
    #2;
    chk("t6_rgb_async", rgb, 0);
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
